// File: rtl/bp_be_issue_ptr_ctrl.sv
// Pointer and occupancy controller for the dual-issue BE issue queue ring.
// Tracks write/issue/commit pointers plus avail/inflight counts; holds no payload.
module bp_be_issue_ptr_ctrl #(
  parameter int unsigned slots_p   = 8,
  parameter int unsigned max_add_p = 2,
  localparam int unsigned ptr_width_lp = $clog2(slots_p),
  localparam int unsigned cnt_width_lp = $clog2(slots_p + 1),
  localparam int unsigned add_width_lp = $clog2(max_add_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [add_width_lp-1:0] enq_cnt_i,
  output logic [add_width_lp-1:0] enq_grant_o,
  input  logic [add_width_lp-1:0] deq_cnt_i,
  output logic [add_width_lp-1:0] deq_grant_o,
  input  logic [add_width_lp-1:0] commit_cnt_i,
  output logic [add_width_lp-1:0] commit_grant_o,
  input  logic                    roll_i,
  input  logic                    flush_i,
  output logic [ptr_width_lp-1:0] wptr_o,
  output logic [ptr_width_lp-1:0] rptr_o,
  output logic [ptr_width_lp-1:0] cptr_o,
  output logic [cnt_width_lp-1:0] free_o,
  output logic [cnt_width_lp-1:0] avail_o,
  output logic [cnt_width_lp-1:0] inflight_o,
  output logic                    full_o,
  output logic                    empty_o
);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
  logic [cnt_width_lp-1:0] avail_q, avail_d, inflight_q, inflight_d;
  logic [cnt_width_lp-1:0] occ, enq_w, deq_w, commit_w;
  logic [add_width_lp-1:0] enq_g, deq_g, commit_g;

  // Compare-and-subtract wrap, so slots_p need not be a power of two.
  function automatic logic [ptr_width_lp-1:0] ptr_add(input logic [ptr_width_lp-1:0] p,
                                                      input logic [add_width_lp-1:0] g);
    logic [ptr_width_lp:0] sum;
    sum = {1'b0, p} + (ptr_width_lp + 1)'(g);
    if (sum >= (ptr_width_lp + 1)'(slots_p)) begin
      sum = sum - (ptr_width_lp + 1)'(slots_p);
    end
    return sum[ptr_width_lp-1:0];
  endfunction

  function automatic logic [add_width_lp-1:0] min_grant(input logic [add_width_lp-1:0] req,
                                                        input logic [cnt_width_lp-1:0] lim);
    if (cnt_width_lp'(req) <= lim) return req;
    return lim[add_width_lp-1:0];
  endfunction

  assign occ    = avail_q + inflight_q;
  assign free_o = cnt_width_lp'(slots_p) - occ;

  // Grants see only registered state: no same-cycle bypass between commit and enq.
  always_comb begin
    enq_g    = '0;
    deq_g    = '0;
    commit_g = '0;
    if (reset_n_i && !flush_i) begin
      enq_g    = min_grant(enq_cnt_i, free_o);
      commit_g = min_grant(commit_cnt_i, inflight_q);
      if (!roll_i) deq_g = min_grant(deq_cnt_i, avail_q);
    end
  end

  assign enq_w    = cnt_width_lp'(enq_g);
  assign deq_w    = cnt_width_lp'(deq_g);
  assign commit_w = cnt_width_lp'(commit_g);

  always_comb begin
    wptr_d     = ptr_add(wptr_q, enq_g);
    rptr_d     = ptr_add(rptr_q, deq_g);
    cptr_d     = ptr_add(cptr_q, commit_g);
    avail_d    = avail_q + enq_w - deq_w;
    inflight_d = inflight_q + deq_w - commit_w;
    if (flush_i) begin
      wptr_d     = cptr_q;
      rptr_d     = cptr_q;
      cptr_d     = cptr_q;
      avail_d    = '0;
      inflight_d = '0;
    end else if (roll_i) begin
      // Retire first, then rewind issue to the new commit point.
      rptr_d     = cptr_d;
      avail_d    = avail_q + inflight_q - commit_w + enq_w;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cptr_q     <= '0;
      avail_q    <= '0;
      inflight_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cptr_q     <= cptr_d;
      avail_q    <= avail_d;
      inflight_q <= inflight_d;
    end
  end

  assign enq_grant_o    = enq_g;
  assign deq_grant_o    = deq_g;
  assign commit_grant_o = commit_g;
  assign wptr_o         = wptr_q;
  assign rptr_o         = rptr_q;
  assign cptr_o         = cptr_q;
  assign avail_o        = avail_q;
  assign inflight_o     = inflight_q;
  assign full_o         = (free_o == '0);
  assign empty_o        = (occ == '0);

  a_param_ok: assert property (@(posedge clk_i) max_add_p <= slots_p);
  a_occ_ok: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ({1'b0, avail_q} + {1'b0, inflight_q}) <= (cnt_width_lp + 1)'(slots_p));

endmodule

// File: tb/tb_bp_be_issue_ptr_ctrl.sv
// Directed bench for bp_be_issue_ptr_ctrl: an 8-slot and a 5-slot instance.
module tb_bp_be_issue_ptr_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   failures  = 0;

  always #5 clk = ~clk;

  // 8-slot instance: ptr 3b, cnt 4b, add 2b
  logic [1:0] a_enq, a_deq, a_com, a_enq_g, a_deq_g, a_com_g;
  logic       a_roll, a_flush, a_full, a_empty;
  logic [2:0] a_wptr, a_rptr, a_cptr;
  logic [3:0] a_free, a_avail, a_infl;

  // 5-slot instance: ptr 3b, cnt 3b, add 2b
  logic [1:0] b_enq, b_deq, b_com, b_enq_g, b_deq_g, b_com_g;
  logic       b_roll, b_flush, b_full, b_empty;
  logic [2:0] b_wptr, b_rptr, b_cptr;
  logic [2:0] b_free, b_avail, b_infl;

  bp_be_issue_ptr_ctrl #(.slots_p(8), .max_add_p(2)) u_dut8 (
    .clk_i(clk), .reset_n_i(rst_n),
    .enq_cnt_i(a_enq), .enq_grant_o(a_enq_g),
    .deq_cnt_i(a_deq), .deq_grant_o(a_deq_g),
    .commit_cnt_i(a_com), .commit_grant_o(a_com_g),
    .roll_i(a_roll), .flush_i(a_flush),
    .wptr_o(a_wptr), .rptr_o(a_rptr), .cptr_o(a_cptr),
    .free_o(a_free), .avail_o(a_avail), .inflight_o(a_infl),
    .full_o(a_full), .empty_o(a_empty)
  );

  bp_be_issue_ptr_ctrl #(.slots_p(5), .max_add_p(2)) u_dut5 (
    .clk_i(clk), .reset_n_i(rst_n),
    .enq_cnt_i(b_enq), .enq_grant_o(b_enq_g),
    .deq_cnt_i(b_deq), .deq_grant_o(b_deq_g),
    .commit_cnt_i(b_com), .commit_grant_o(b_com_g),
    .roll_i(b_roll), .flush_i(b_flush),
    .wptr_o(b_wptr), .rptr_o(b_rptr), .cptr_o(b_cptr),
    .free_o(b_free), .avail_o(b_avail), .inflight_o(b_infl),
    .full_o(b_full), .empty_o(b_empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] e, input logic [1:0] d, input logic [1:0] c,
                         input logic r, input logic f);
    a_enq = e; a_deq = d; a_com = c; a_roll = r; a_flush = f;
  endtask

  task automatic do_reset();
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    b_enq = 2'd0; b_deq = 2'd0; b_com = 2'd0; b_roll = 1'b0; b_flush = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(2'd2, 2'd2, 2'd2, 1'b0, 1'b0);
    #2;
    tests_run++;
    if ({a_wptr, a_rptr, a_cptr} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ptrs: got w%0d r%0d c%0d want 0 0 0", a_wptr, a_rptr, a_cptr);
    end
    tests_run++;
    if (a_free !== 4'd8 || a_avail !== 4'd0 || a_infl !== 4'd0) begin
      failures++;
      $display("FAIL reset_counts: got free%0d avail%0d infl%0d want 8 0 0",
               a_free, a_avail, a_infl);
    end
    tests_run++;
    if (a_empty !== 1'b1 || a_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got empty%0b full%0b want 1 0", a_empty, a_full);
    end
    tests_run++;
    if ({a_enq_g, a_deq_g, a_com_g} !== 6'd0) begin
      failures++;
      $display("FAIL reset_grants: got %0d %0d %0d want 0 0 0", a_enq_g, a_deq_g, a_com_g);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    do_reset();
    drive_a(2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (a_enq_g !== 2'd2 || a_wptr !== 3'(2 * i)) begin
        failures++;
        $display("FAIL fill_%0d: got grant%0d wptr%0d want 2 %0d", i, a_enq_g, a_wptr, 2 * i);
      end
      step();
    end
    #1;
    tests_run++;
    if (a_wptr !== 3'd0 || a_full !== 1'b1 || a_free !== 4'd0 || a_avail !== 4'd8) begin
      failures++;
      $display("FAIL fill_full: got wptr%0d full%0b free%0d avail%0d want 0 1 0 8",
               a_wptr, a_full, a_free, a_avail);
    end
    tests_run++;
    if (a_enq_g !== 2'd0) begin
      failures++;
      $display("FAIL fill_fifth_grant: got %0d want 0", a_enq_g);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_wrap5();
    logic [1:0] te[7] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [1:0] td[7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [1:0] tc[7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    logic [2:0] xw[7] = '{3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
    logic [2:0] xr[7] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4};
    logic [2:0] xc[7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd4, 3'd4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      b_enq = te[i]; b_deq = td[i]; b_com = tc[i];
      step();
      tests_run++;
      if (b_wptr !== xw[i] || b_rptr !== xr[i] || b_cptr !== xc[i]) begin
        failures++;
        $display("FAIL wrap5_row%0d: got w%0d r%0d c%0d want %0d %0d %0d",
                 i, b_wptr, b_rptr, b_cptr, xw[i], xr[i], xc[i]);
      end
    end
    tests_run++;
    if (b_avail !== 3'd2 || b_infl !== 3'd0 || b_free !== 3'd3) begin
      failures++;
      $display("FAIL wrap5_counts: got avail%0d infl%0d free%0d want 2 0 3",
               b_avail, b_infl, b_free);
    end
    b_enq = 2'd0; b_deq = 2'd0; b_com = 2'd0;
  endtask

  task automatic test_full_commit();
    do_reset();
    drive_a(2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    repeat (4) step();
    drive_a(2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    drive_a(2'd2, 2'd0, 2'd2, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (a_enq_g !== 2'd0 || a_com_g !== 2'd2) begin
      failures++;
      $display("FAIL full_commit_same: got enq%0d com%0d want 0 2", a_enq_g, a_com_g);
    end
    step();
    #1;
    tests_run++;
    if (a_enq_g !== 2'd2 || a_com_g !== 2'd0 || a_free !== 4'd2) begin
      failures++;
      $display("FAIL full_commit_next: got enq%0d com%0d free%0d want 2 0 2",
               a_enq_g, a_com_g, a_free);
    end
    step();
    tests_run++;
    if (a_wptr !== 3'd2 || a_cptr !== 3'd2 || a_full !== 1'b1) begin
      failures++;
      $display("FAIL full_commit_after: got w%0d c%0d full%0b want 2 2 1",
               a_wptr, a_cptr, a_full);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_roll();
    do_reset();
    drive_a(2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    drive_a(2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    drive_a(2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (a_avail !== 4'd3 || a_infl !== 4'd2 || a_rptr !== 3'd2) begin
      failures++;
      $display("FAIL roll_setup: got avail%0d infl%0d r%0d want 3 2 2", a_avail, a_infl, a_rptr);
    end
    drive_a(2'd0, 2'd2, 2'd1, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (a_deq_g !== 2'd0 || a_com_g !== 2'd1) begin
      failures++;
      $display("FAIL roll_grants: got deq%0d com%0d want 0 1", a_deq_g, a_com_g);
    end
    step();
    tests_run++;
    if (a_rptr !== 3'd1 || a_cptr !== 3'd1 || a_wptr !== 3'd5) begin
      failures++;
      $display("FAIL roll_ptrs: got w%0d r%0d c%0d want 5 1 1", a_wptr, a_rptr, a_cptr);
    end
    tests_run++;
    if (a_avail !== 4'd4 || a_infl !== 4'd0) begin
      failures++;
      $display("FAIL roll_counts: got avail%0d infl%0d want 4 0", a_avail, a_infl);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    drive_a(2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    drive_a(2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    drive_a(2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    step();
    drive_a(2'd2, 2'd2, 2'd2, 1'b1, 1'b1);
    #1;
    tests_run++;
    if ({a_enq_g, a_deq_g, a_com_g} !== 6'd0) begin
      failures++;
      $display("FAIL flush_grants: got %0d %0d %0d want 0 0 0", a_enq_g, a_deq_g, a_com_g);
    end
    step();
    tests_run++;
    if (a_wptr !== 3'd1 || a_rptr !== 3'd1 || a_cptr !== 3'd1) begin
      failures++;
      $display("FAIL flush_ptrs: got w%0d r%0d c%0d want 1 1 1", a_wptr, a_rptr, a_cptr);
    end
    tests_run++;
    if (a_empty !== 1'b1 || a_free !== 4'd8 || a_avail !== 4'd0 || a_infl !== 4'd0) begin
      failures++;
      $display("FAIL flush_counts: got empty%0b free%0d avail%0d infl%0d want 1 8 0 0",
               a_empty, a_free, a_avail, a_infl);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_a(2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    repeat (4) step();
    drive_a(2'd2, 2'd2, 2'd2, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_wptr, a_rptr, a_cptr} !== 9'd0 || a_free !== 4'd8) begin
      failures++;
      $display("FAIL reset_mid_state: got w%0d r%0d c%0d free%0d want 0 0 0 8",
               a_wptr, a_rptr, a_cptr, a_free);
    end
    tests_run++;
    if ({a_enq_g, a_deq_g, a_com_g} !== 6'd0) begin
      failures++;
      $display("FAIL reset_mid_grants: got %0d %0d %0d want 0 0 0", a_enq_g, a_deq_g, a_com_g);
    end
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    b_enq = 2'd0; b_deq = 2'd0; b_com = 2'd0; b_roll = 1'b0; b_flush = 1'b0;
    test_reset();
    test_fill();
    test_wrap5();
    test_full_commit();
    test_roll();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
